// File: rtl/reset_sequencer_pkg.sv
// Shared types and default parameters for the multi-domain reset sequencer.
package ResetSequencerTypes;

    typedef enum logic [1:0] {
        RST_SEQ_HOLD,
        RST_SEQ_RELEASE,
        RST_SEQ_RUN
    } RstSeqState;

    localparam int DEF_NUM_DOMAINS             = 4;
    localparam int DEF_CYCLE_OF_RESET_SEQUENCE = 10000;
    localparam int DEF_STAGE_GAP               = 16;
    localparam int DEF_SYNC_STAGES             = 2;
    localparam int DEF_LOCK_FILTER             = 8;

endpackage

// File: rtl/reset_sequencer_lock_qualifier.sv
// Synchronises the clock generator's lock flag and qualifies it only after it
// has stayed high for LOCK_FILTER consecutive cycles.
module lock_qualifier
    import ResetSequencerTypes::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
    input  logic clk,
    input  logic rstTrigger,
    input  logic locked,
    output logic lockSync,
    output logic lockOk
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam logic [FW-1:0] FILTER_FULL = FW'(LOCK_FILTER);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [FW-1:0]          filter_q;
    logic [FW-1:0]          filter_d;

    // Filter saturates once full so lockOk stays up while lockSync stays high.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
        filter_d = filter_q;
        if (!sync_q[SYNC_STAGES-1]) begin
            filter_d = '0;
        end else if (filter_q != FILTER_FULL) begin
            filter_d = filter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rstTrigger) begin
        if (rstTrigger) begin
            sync_q   <= '0;
            filter_q <= '0;
        end else begin
            sync_q   <= sync_d;
            filter_q <= filter_d;
        end
    end

    assign lockSync = sync_q[SYNC_STAGES-1];
    assign lockOk   = (filter_q == FILTER_FULL);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains until lock is qualified for a fixed interval, then
// releases them one by one in index order, spaced by STAGE_GAP cycles.
module reset_sequencer
    import ResetSequencerTypes::*;
#(
    parameter int NUM_DOMAINS             = DEF_NUM_DOMAINS,
    parameter int CYCLE_OF_RESET_SEQUENCE = DEF_CYCLE_OF_RESET_SEQUENCE,
    parameter int STAGE_GAP               = DEF_STAGE_GAP,
    parameter int SYNC_STAGES             = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER             = DEF_LOCK_FILTER
) (
    input  logic                   clk,
    input  logic                   rstTrigger,
    input  logic                   locked,
    input  logic                   softRstReq,
    output logic [NUM_DOMAINS-1:0] rst,
    output logic                   rstStart,
    output logic                   done
);

    localparam int HW = $clog2(CYCLE_OF_RESET_SEQUENCE) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam int SW = $clog2(NUM_DOMAINS) + 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(CYCLE_OF_RESET_SEQUENCE - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_DOMAINS - 1);

    RstSeqState             state_q;
    RstSeqState             state_d;
    logic [HW-1:0]          hold_count_q;
    logic [HW-1:0]          hold_count_d;
    logic [GW-1:0]          gap_count_q;
    logic [GW-1:0]          gap_count_d;
    logic [SW-1:0]          stage_idx_q;
    logic [SW-1:0]          stage_idx_d;
    logic [NUM_DOMAINS-1:0] rst_q;
    logic [NUM_DOMAINS-1:0] rst_d;
    logic [SW-1:0]          next_stage;
    logic                   lock_sync;
    logic                   lock_ok;

    lock_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_qualifier (
        .clk        (clk),
        .rstTrigger (rstTrigger),
        .locked     (locked),
        .lockSync   (lock_sync),
        .lockOk     (lock_ok)
    );

    always_comb begin
        state_d      = state_q;
        hold_count_d = hold_count_q;
        gap_count_d  = gap_count_q;
        stage_idx_d  = stage_idx_q;
        rst_d        = rst_q;
        next_stage   = stage_idx_q + 1'b1;

        case (state_q)
            RST_SEQ_HOLD: begin
                if (!lock_sync) begin
                    hold_count_d = '0;
                end else if (lock_ok) begin
                    if (hold_count_q == HOLD_LAST) begin
                        hold_count_d = '0;
                        gap_count_d  = '0;
                        stage_idx_d  = '0;
                        if (NUM_DOMAINS == 1) begin
                            state_d = RST_SEQ_RUN;
                            rst_d   = '0;
                        end else begin
                            state_d  = RST_SEQ_RELEASE;
                            rst_d[0] = 1'b0;
                        end
                    end else begin
                        hold_count_d = hold_count_q + 1'b1;
                    end
                end
            end
            RST_SEQ_RELEASE: begin
                if (gap_count_q == GAP_LAST) begin
                    gap_count_d = '0;
                    stage_idx_d = next_stage;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (SW'(i) == next_stage) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    if (next_stage == STAGE_LAST) begin
                        state_d = RST_SEQ_RUN;
                    end
                end else begin
                    gap_count_d = gap_count_q + 1'b1;
                end
            end
            RST_SEQ_RUN: begin
                rst_d = '0;
            end
            default: begin
                state_d = RST_SEQ_HOLD;
                rst_d   = '1;
            end
        endcase

        // Lock loss and soft requests both restart the whole sequence once
        // any domain may already be out of reset; HOLD handles lock loss itself.
        if ((state_q != RST_SEQ_HOLD) && (!lock_sync || softRstReq)) begin
            state_d      = RST_SEQ_HOLD;
            rst_d        = '1;
            hold_count_d = '0;
            gap_count_d  = '0;
            stage_idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rstTrigger) begin
        if (rstTrigger) begin
            state_q      <= RST_SEQ_HOLD;
            hold_count_q <= '0;
            gap_count_q  <= '0;
            stage_idx_q  <= '0;
            rst_q        <= '1;
        end else begin
            state_q      <= state_d;
            hold_count_q <= hold_count_d;
            gap_count_q  <= gap_count_d;
            stage_idx_q  <= stage_idx_d;
            rst_q        <= rst_d;
        end
    end

    assign rst      = rst_q;
    assign rstStart = (state_q == RST_SEQ_HOLD) && (hold_count_q == '0);
    assign done     = (state_q == RST_SEQ_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: a progress-count model of the release schedule is
// compared every cycle, with hand-computed edge pins for the directed cases.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int C    = 8;
    localparam int G    = 4;
    localparam int S    = 2;
    localparam int F    = 2;
    localparam int FULL = C + (N - 1) * G;

    logic         clk = 1'b0;
    logic         rstTrigger;
    logic         locked;
    logic         softRstReq;
    logic [N-1:0] rst;
    logic         rstStart;
    logic         done;

    int check_cnt = 0;
    int err_cnt   = 0;
    int edge_num  = 0;

    logic [S-1:0] m_hist;
    int           m_streak;
    int           m_elapsed;

    reset_sequencer #(
        .NUM_DOMAINS             (N),
        .CYCLE_OF_RESET_SEQUENCE (C),
        .STAGE_GAP               (G),
        .SYNC_STAGES             (S),
        .LOCK_FILTER             (F)
    ) dut (
        .clk        (clk),
        .rstTrigger (rstTrigger),
        .locked     (locked),
        .softRstReq (softRstReq),
        .rst        (rst),
        .rstStart   (rstStart),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstTrigger) edge_num <= -1;
        else            edge_num <= edge_num + 1;
    end

    // Model: m_elapsed counts progress cycles since the sequence (re)started;
    // every output follows from that single number.
    always @(posedge clk or posedge rstTrigger) begin
        if (rstTrigger) begin
            m_hist    <= '0;
            m_streak  <= 0;
            m_elapsed <= 0;
        end else begin
            m_hist   <= {m_hist[S-2:0], locked};
            m_streak <= !m_hist[S-1] ? 0 : (m_streak < F ? m_streak + 1 : m_streak);
            if (!m_hist[S-1])
                m_elapsed <= 0;
            else if (m_elapsed >= C && softRstReq)
                m_elapsed <= 0;
            else if (m_elapsed >= C || m_streak >= F)
                m_elapsed <= (m_elapsed < FULL) ? m_elapsed + 1 : FULL;
        end
    end

    function automatic logic [N-1:0] model_rst(input int e);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (e < C + i * G);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_num);
        end
    endtask

    task automatic compare_model();
        check_output("model_rst", 32'(rst), 32'(model_rst(m_elapsed)));
        check_output("model_rstStart", 32'(rstStart), 32'(m_elapsed == 0));
        check_output("model_done", 32'(done), 32'(m_elapsed >= FULL));
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic run_to(input int e);
        int guard = 0;
        while (edge_num < e && guard < 500) begin
            step();
            guard++;
        end
        if (edge_num < e) check_output("run_to_timeout", 32'(edge_num), 32'(e));
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            locked     = ($urandom_range(0, 199) != 0);
            softRstReq = ($urandom_range(0, 99) == 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstTrigger = 1'b1;
        locked     = 1'b0;
        softRstReq = 1'b0;
        step();
        step();
        check_output("reset_rst", 32'(rst), 32'h7);
        check_output("reset_rstStart", 32'(rstStart), 32'h1);
        check_output("reset_done", 32'(done), 32'h0);
        rstTrigger = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstTrigger = 1'b0;
        locked     = 1'b0;
        softRstReq = 1'b0;
        #1 rstTrigger = 1'b1;

        // Power-up, then soft reset from RUN.
        do_reset();
        run_to(0);
        locked = 1'b1;
        run_to(4);  check_output("pu_rstStart_e4", 32'(rstStart), 32'h1);
                    check_output("pu_rst_e4", 32'(rst), 32'h7);
        run_to(5);  check_output("pu_rstStart_e5", 32'(rstStart), 32'h0);
        run_to(11); check_output("pu_rst_e11", 32'(rst), 32'h7);
        run_to(12); check_output("pu_rst_e12", 32'(rst), 32'h6);
                    check_output("pu_done_e12", 32'(done), 32'h0);
        run_to(16); check_output("pu_rst_e16", 32'(rst), 32'h4);
        run_to(20); check_output("pu_rst_e20", 32'(rst), 32'h0);
                    check_output("pu_done_e20", 32'(done), 32'h1);
        run_to(29); softRstReq = 1'b1;
        run_to(30); softRstReq = 1'b0;
                    check_output("soft_rst_e30", 32'(rst), 32'h7);
                    check_output("soft_rstStart_e30", 32'(rstStart), 32'h1);
                    check_output("soft_done_e30", 32'(done), 32'h0);
        run_to(37); check_output("soft_rst_e37", 32'(rst), 32'h7);
        run_to(38); check_output("soft_rst_e38", 32'(rst), 32'h6);
        run_to(45); check_output("soft_done_e45", 32'(done), 32'h0);
        run_to(46); check_output("soft_done_e46", 32'(done), 32'h1);

        // One-cycle lock glitch in HOLD, then lock loss during RELEASE.
        do_reset();
        run_to(0);  locked = 1'b1;
        run_to(7);  locked = 1'b0;
        run_to(8);  locked = 1'b1;
        run_to(9);  check_output("glitch_rstStart_e9", 32'(rstStart), 32'h0);
        run_to(10); check_output("glitch_rstStart_e10", 32'(rstStart), 32'h1);
        run_to(19); check_output("glitch_rst_e19", 32'(rst), 32'h7);
        run_to(20); check_output("glitch_rst_e20", 32'(rst), 32'h6);
        run_to(24); locked = 1'b0;
        run_to(26); check_output("loss_rst_e26", 32'(rst), 32'h4);
        run_to(27); check_output("loss_rst_e27", 32'(rst), 32'h7);
                    check_output("loss_done_e27", 32'(done), 32'h0);
        run_to(29); locked = 1'b1;
        run_to(40); check_output("relock_rst_e40", 32'(rst), 32'h7);
        run_to(41); check_output("relock_rst_e41", 32'(rst), 32'h6);
        run_to(49); check_output("relock_done_e49", 32'(done), 32'h1);

        // Randomised lock drops and soft requests against the model.
        apply_stimulus(1500);

        // Settle into RUN, then assert rstTrigger between clock edges.
        step();
        locked     = 1'b1;
        softRstReq = 1'b0;
        repeat (40) step();
        check_output("async_pre_done", 32'(done), 32'h1);
        #2 rstTrigger = 1'b1;
        #1;
        check_output("async_rst", 32'(rst), 32'h7);
        check_output("async_done", 32'(done), 32'h0);
        check_output("async_rstStart", 32'(rstStart), 32'h1);
        step();
        step();
        rstTrigger = 1'b0;

        // Soft request held through HOLD must not disturb release timing.
        do_reset();
        run_to(0);  locked = 1'b1; softRstReq = 1'b1;
        run_to(11); softRstReq = 1'b0;
                    check_output("holdsoft_rst_e11", 32'(rst), 32'h7);
        run_to(12); check_output("holdsoft_rst_e12", 32'(rst), 32'h6);
        run_to(20); check_output("holdsoft_rst_e20", 32'(rst), 32'h0);
                    check_output("holdsoft_done_e20", 32'(done), 32'h1);
        step();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
